// File: rtl/led_pkg.sv
// Shared types and constants for the LED burst scheduler.
//   state_t       : FSM state encoding (IDLE, ON, OFF, FINISH)
//   LED_ON/LED_OFF: light drive levels
//   DEF_*_CYCLES  : default blink phase lengths
//   max_u         : constant helper for sizing the phase counter
package led_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ON     = 2'd1,
        OFF    = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic LED_ON  = 1'b1;
    localparam logic LED_OFF = 1'b0;

    localparam int unsigned DEF_ON_CYCLES  = 2;
    localparam int unsigned DEF_OFF_CYCLES = 2;

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_burst_scheduler_if.sv
// Requester-side bus of the LED burst scheduler.
//   req       : per-requester burst request level
//   count     : flattened blink counts, requester i at [i*CNT_W +: CNT_W]
//   grant     : one-hot current owner
//   done      : one-hot completion pulse
//   busy      : scheduler not idle
//   light_out : LED drive
interface led_burst_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] count;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     light_out;

    modport master (
        output req, count,
        input  grant, done, busy, light_out
    );

    modport slave (
        input  req, count,
        output grant, done, busy, light_out
    );
endinterface

// File: rtl/led_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
//   req     : request vector
//   ptr     : search start index (register owned by the parent)
//   grant_c : one-hot winner, zero when no request
//   idx_c   : winner index (0 when no request)
module led_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [PTR_W-1:0]   idx_c
);

    int unsigned cand;
    logic        found;

    // Walk candidates ptr, ptr+1, ... modulo NUM_REQ; keep the first hit.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[PTR_W'(cand)]) begin
                found                 = 1'b1;
                idx_c                 = PTR_W'(cand);
                grant_c[PTR_W'(cand)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_burst_scheduler.sv
// Shares one LED among NUM_REQ requesters: round-robin grant, then N blinks
// of ON_CYCLES on / OFF_CYCLES off, then a one-cycle done pulse to the owner.
//   clock : sole clock
//   reset : synchronous active-high reset
//   bus   : requester bus (req/count in, grant/done/busy/light_out out)
module led_burst_scheduler
    import led_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
    parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    led_burst_scheduler_if.slave  bus
);

    localparam int unsigned PTR_W  = $clog2(NUM_REQ);
    localparam int unsigned PH_MAX = max_u(ON_CYCLES, OFF_CYCLES);
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [PH_W-1:0]    phase_q, phase_d;

    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic               light_q, light_d;

    logic [NUM_REQ-1:0] win_onehot_c;
    logic [PTR_W-1:0]   win_idx_c;
    logic [CNT_W-1:0]   win_count_c;

    led_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.req),
        .ptr     (ptr_q),
        .grant_c (win_onehot_c),
        .idx_c   (win_idx_c)
    );

    assign win_count_c = bus.count[CNT_W*int'(win_idx_c) +: CNT_W];

    // State, pointer, counters and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            remaining_q <= '0;
            phase_q     <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            light_q     <= LED_OFF;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            remaining_q <= remaining_d;
            phase_q     <= phase_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            light_q     <= light_d;
        end
    end

    // Next state; phase_q counts cycles already spent in the current phase.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        remaining_d = remaining_q;
        phase_d     = phase_q;
        case (state_q)
            IDLE: begin
                if (|win_onehot_c) begin
                    owner_d     = win_idx_c;
                    remaining_d = win_count_c;
                    phase_d     = PH_W'(1);
                    state_d     = (win_count_c != '0) ? ON : FINISH;
                end
            end
            ON: begin
                if (phase_q == PH_W'(ON_CYCLES)) begin
                    phase_d = PH_W'(1);
                    state_d = OFF;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            OFF: begin
                if (phase_q == PH_W'(OFF_CYCLES)) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    phase_d     = PH_W'(1);
                    state_d     = (remaining_q == CNT_W'(1)) ? FINISH : ON;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            FINISH: begin
                state_d     = IDLE;
                phase_d     = '0;
                remaining_d = '0;
                ptr_d       = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        grant_d = '0;
        done_d  = '0;
        busy_d  = 1'b0;
        light_d = LED_OFF;
        if (state_d != IDLE) begin
            grant_d = NUM_REQ'(1) << owner_d;
            busy_d  = 1'b1;
        end
        if (state_d == FINISH) begin
            done_d = grant_d;
        end
        if (state_d == ON) begin
            light_d = LED_ON;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.light_out = light_q;

endmodule

// File: tb/tb_led_burst_scheduler.sv
// Scoreboard bench for led_burst_scheduler: each scenario pushes the expected
// per-cycle {grant, done, busy, light_out} trace, then pops one entry per
// cycle and compares it against the DUT.
module tb_led_burst_scheduler;

    localparam int unsigned NR    = 4;
    localparam int unsigned CW    = 4;
    localparam int unsigned ON_C  = 2;
    localparam int unsigned OFF_C = 2;

    typedef struct packed {
        logic [NR-1:0] grant;
        logic [NR-1:0] done;
        logic          busy;
        logic          light;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int   vectors     = 0;
    int   miscompares = 0;
    obs_t exp_q[$];
    obs_t exp_e;
    obs_t obs_e;

    led_burst_scheduler_if #(.NUM_REQ(NR), .CNT_W(CW)) bus ();

    led_burst_scheduler #(
        .NUM_REQ(NR), .CNT_W(CW), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic void push_idle(int n);
        obs_t e;
        e = '0;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endfunction

    // Reference trace of one burst for requester who with n blinks.
    function automatic void push_burst(int who, int n);
        obs_t e;
        e       = '0;
        e.grant = NR'(1 << who);
        e.busy  = 1'b1;
        for (int k = 0; k < n; k++) begin
            e.light = 1'b1;
            for (int c = 0; c < int'(ON_C); c++) exp_q.push_back(e);
            e.light = 1'b0;
            for (int c = 0; c < int'(OFF_C); c++) exp_q.push_back(e);
        end
        e.light = 1'b0;
        e.done  = e.grant;
        exp_q.push_back(e);
    endfunction

    task automatic set_count(int who, int n);
        bus.count[who*CW +: CW] = CW'(n);
    endtask

    task automatic test_reset;
        int cyc = 0;
        reset   = 1'b1;
        bus.req = '0;
        bus.count = '0;
        @(posedge clock); #1;
        push_idle(12);
        while (exp_q.size() != 0) begin
            @(posedge clock); #1;
            cyc++;
            exp_e = exp_q.pop_front();
            obs_e = {bus.grant, bus.done, bus.busy, bus.light_out};
            vectors++;
            if (obs_e !== exp_e) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %b want %b (grant,done,busy,light)", cyc, obs_e, exp_e);
            end
            if (cyc == 2) reset = 1'b0;
        end
    endtask

    task automatic test_single_burst;
        int cyc = 0;
        int dones = 0;
        set_count(1, 3);
        bus.req = 4'b0010;
        push_burst(1, 3);
        push_idle(2);
        while (exp_q.size() != 0) begin
            @(posedge clock); #1;
            cyc++;
            exp_e = exp_q.pop_front();
            obs_e = {bus.grant, bus.done, bus.busy, bus.light_out};
            vectors++;
            if (obs_e !== exp_e) begin
                miscompares++;
                $display("FAIL single_burst cyc %0d: got %b want %b (grant,done,busy,light)", cyc, obs_e, exp_e);
            end
            if (exp_e.done != '0) dones++;
            if (dones == 1) bus.req = '0;
        end
    endtask

    task automatic test_zero_count;
        int cyc = 0;
        set_count(2, 0);
        bus.req = 4'b0100;
        push_burst(2, 0);
        push_idle(2);
        while (exp_q.size() != 0) begin
            @(posedge clock); #1;
            cyc++;
            exp_e = exp_q.pop_front();
            obs_e = {bus.grant, bus.done, bus.busy, bus.light_out};
            vectors++;
            if (obs_e !== exp_e) begin
                miscompares++;
                $display("FAIL zero_count cyc %0d: got %b want %b (grant,done,busy,light)", cyc, obs_e, exp_e);
            end
            if (exp_e.done != '0) bus.req = '0;
        end
    endtask

    task automatic test_round_robin;
        int cyc = 0;
        int dones = 0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < int'(NR); i++) set_count(i, 1);
        bus.req = 4'b1111;
        push_burst(0, 1); push_idle(1);
        push_burst(1, 1); push_idle(1);
        push_burst(2, 1); push_idle(1);
        push_burst(3, 1); push_idle(1);
        push_burst(0, 1); push_idle(2);
        while (exp_q.size() != 0) begin
            @(posedge clock); #1;
            cyc++;
            exp_e = exp_q.pop_front();
            obs_e = {bus.grant, bus.done, bus.busy, bus.light_out};
            vectors++;
            if (obs_e !== exp_e) begin
                miscompares++;
                $display("FAIL round_robin cyc %0d: got %b want %b (grant,done,busy,light)", cyc, obs_e, exp_e);
            end
            if (exp_e.done != '0) dones++;
            if (dones == 5) bus.req = '0;
        end
    endtask

    task automatic test_wrap;
        int cyc = 0;
        int dones = 0;
        // pointer is 1 here; serving requester 2 moves it to 3
        set_count(2, 1);
        bus.req = 4'b0100;
        push_burst(2, 1);
        push_idle(1);
        push_burst(3, 1);
        push_idle(1);
        push_burst(0, 1);
        push_idle(2);
        while (exp_q.size() != 0) begin
            @(posedge clock); #1;
            cyc++;
            exp_e = exp_q.pop_front();
            obs_e = {bus.grant, bus.done, bus.busy, bus.light_out};
            vectors++;
            if (obs_e !== exp_e) begin
                miscompares++;
                $display("FAIL wrap cyc %0d: got %b want %b (grant,done,busy,light)", cyc, obs_e, exp_e);
            end
            if (exp_e.done != '0) dones++;
            if (dones == 1 && exp_e.done != '0) bus.req = 4'b1001;
            if (dones == 3) bus.req = '0;
        end
    endtask

    task automatic test_robustness;
        int cyc = 0;
        int dones = 0;
        set_count(1, 3);
        set_count(0, 1);
        bus.req = 4'b0010;
        push_burst(1, 3);
        push_idle(1);
        push_burst(0, 1);
        push_idle(2);
        while (exp_q.size() != 0) begin
            @(posedge clock); #1;
            cyc++;
            exp_e = exp_q.pop_front();
            obs_e = {bus.grant, bus.done, bus.busy, bus.light_out};
            vectors++;
            if (obs_e !== exp_e) begin
                miscompares++;
                $display("FAIL robustness cyc %0d: got %b want %b (grant,done,busy,light)", cyc, obs_e, exp_e);
            end
            if (cyc == 1) begin
                bus.req = '0;
                set_count(1, 7);
            end
            if (cyc == 3) bus.req = 4'b0001;
            if (exp_e.done != '0) dones++;
            if (dones == 2) bus.req = '0;
        end
    endtask

    task automatic test_reset_mid_burst;
        int cyc = 0;
        int dones = 0;
        set_count(1, 3);
        bus.req = 4'b0010;
        push_burst(1, 3);
        while (exp_q.size() > 6) void'(exp_q.pop_back());
        push_idle(2);
        while (exp_q.size() != 0) begin
            @(posedge clock); #1;
            cyc++;
            exp_e = exp_q.pop_front();
            obs_e = {bus.grant, bus.done, bus.busy, bus.light_out};
            vectors++;
            if (obs_e !== exp_e) begin
                miscompares++;
                $display("FAIL reset_mid cyc %0d: got %b want %b (grant,done,busy,light)", cyc, obs_e, exp_e);
            end
            if (cyc == 6) begin
                reset   = 1'b1;
                bus.req = '0;
            end
            if (cyc == 7) reset = 1'b0;
        end
        // pointer must be back at 0: requester 0 beats requester 3
        cyc = 0;
        set_count(0, 1);
        set_count(3, 1);
        bus.req = 4'b1001;
        push_burst(0, 1);
        push_idle(2);
        while (exp_q.size() != 0) begin
            @(posedge clock); #1;
            cyc++;
            exp_e = exp_q.pop_front();
            obs_e = {bus.grant, bus.done, bus.busy, bus.light_out};
            vectors++;
            if (obs_e !== exp_e) begin
                miscompares++;
                $display("FAIL post_reset cyc %0d: got %b want %b (grant,done,busy,light)", cyc, obs_e, exp_e);
            end
            if (exp_e.done != '0) dones++;
            if (dones == 1) bus.req = '0;
        end
    endtask

    initial begin
        bus.req   = '0;
        bus.count = '0;
        test_reset();
        test_single_burst();
        test_zero_count();
        test_round_robin();
        test_wrap();
        test_robustness();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
